// File: rtl/display_view_scheduler.sv
// Arbitrates view requests, strikes one CPU sample per served request, waits for the CPU
// outputs to settle, then freezes a snapshot on the seven-segment display for a fixed time.
module display_view_scheduler #(
    parameter logic [31:0] HOLD_CYCLES = 32'd200_000_000,
    parameter logic [3:0]  SAMPLE_LAT  = 4'd2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_result,
    input  logic        i_req_instr,
    input  logic        i_req_flags,
    input  logic        i_start_cpu,
    input  logic        i_xfer_done,
    input  logic        i_halt,
    input  logic [7:0]  i_pc,
    input  logic [7:0]  i_opcode,
    input  logic [4:0]  i_flags,
    input  logic [15:0] i_res_hi,
    input  logic [15:0] i_res_lo,
    input  logic [7:0]  i_max_addr,
    output logic        o_sample,
    output logic [2:0]  o_view_sel,
    output logic [31:0] o_disp_data,
    output logic        o_disp_valid,
    output logic        o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_WAIT, S_SHOW} state_t;

    localparam logic [2:0] VIEW_BLANK   = 3'd0;
    localparam logic [2:0] VIEW_MAXADDR = 3'd1;
    localparam logic [2:0] VIEW_RESULT  = 3'd2;
    localparam logic [2:0] VIEW_INSTR   = 3'd3;
    localparam logic [2:0] VIEW_FLAGS   = 3'd4;

    state_t      state, state_nx;
    logic [2:0]  pend, pend_nx;
    logic [2:0]  req_all, grant;
    logic [2:0]  src, src_nx;
    logic [31:0] cnt, cnt_nx;
    logic [2:0]  view_nx;
    logic [31:0] data_nx;
    logic        start_svc;

    // Pending bits are {result, instr, flags}; live pulses are folded in so same-cycle requests count.
    assign req_all = pend | {i_req_result, i_req_instr, i_req_flags};

    always_comb begin
        grant = 3'b000;
        if (req_all[2])      grant = 3'b100;
        else if (req_all[1]) grant = 3'b010;
        else if (req_all[0]) grant = 3'b001;
    end

    always_comb begin
        state_nx  = state;
        pend_nx   = req_all;
        src_nx    = src;
        cnt_nx    = cnt;
        view_nx   = o_view_sel;
        data_nx   = o_disp_data;
        start_svc = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_halt) begin
                    view_nx = VIEW_RESULT;
                    data_nx = {i_res_hi, i_res_lo};
                end else if (!i_start_cpu && i_xfer_done) begin
                    view_nx = VIEW_MAXADDR;
                    data_nx = {24'd0, i_max_addr};
                end else begin
                    view_nx = VIEW_BLANK;
                    data_nx = 32'd0;
                end
                start_svc = |req_all;
            end
            S_SAMPLE: begin
                state_nx = S_WAIT;
                cnt_nx   = {28'd0, SAMPLE_LAT} - 32'd1;
            end
            S_WAIT: begin
                if (cnt == 32'd0) begin
                    state_nx = S_SHOW;
                    cnt_nx   = HOLD_CYCLES - 32'd1;
                    view_nx  = src;
                    case (src)
                        VIEW_RESULT: data_nx = {i_res_hi, i_res_lo};
                        VIEW_INSTR:  data_nx = {16'd0, i_pc, i_opcode};
                        default:     data_nx = {27'd0, i_flags};
                    endcase
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            S_SHOW: begin
                if (cnt == 32'd0) begin
                    if (|req_all) start_svc = 1'b1;
                    else          state_nx  = S_IDLE;
                end else begin
                    cnt_nx = cnt - 32'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // The served bit is consumed on the way into SAMPLE; everything else stays queued.
        if (start_svc) begin
            state_nx = S_SAMPLE;
            pend_nx  = req_all & ~grant;
            if (grant[2])      src_nx = VIEW_RESULT;
            else if (grant[1]) src_nx = VIEW_INSTR;
            else               src_nx = VIEW_FLAGS;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend        <= 3'd0;
            src         <= VIEW_BLANK;
            cnt         <= 32'd0;
            o_view_sel  <= VIEW_BLANK;
            o_disp_data <= 32'd0;
        end else begin
            pend        <= pend_nx;
            src         <= src_nx;
            cnt         <= cnt_nx;
            o_view_sel  <= view_nx;
            o_disp_data <= data_nx;
        end
    end

    assign o_sample     = (state == S_SAMPLE);
    assign o_disp_valid = (state == S_SHOW);
    assign o_busy       = (state != S_IDLE);

endmodule
